// File: rtl/pid_steer_ctrl.sv
// pid_steer_ctrl: heading PID for the tour robot. It turns a signed heading error
// into left/right wheel speeds around a forward command. Runtime P/D gains, a
// saturating integrator, D-history priming, speed clamping and a 2-stage pipe.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   moving    in   1 = active; 0 = clear state, speeds forced to 0
//   err_vld   in   one-cycle strobe qualifying error
//   error     in   signed heading error (ERR_W)
//   frwrd     in   unsigned forward speed command (FRWRD_W)
//   p_coeff   in   unsigned P gain, sampled with error
//   d_coeff   in   unsigned D gain, sampled with error
//   lft_spd   out  signed left wheel speed, registered (SPD_W)
//   rght_spd  out  signed right wheel speed, registered (SPD_W)
//   spd_vld   out  one-cycle pulse when speeds update
//   i_sat     out  integrator sat at its clamp after the last update
//
// FSM states:
//   IDLE  | not moving; state cleared
//   PRIME | moving, no error history yet; next sample gets D = 0
//   RUN   | moving with valid error history; D term active
module pid_steer_ctrl #(
  parameter int ERR_W     = 12,
  parameter int SAT_W     = 10,
  parameter int FRWRD_W   = 10,
  parameter int SPD_W     = 11,
  parameter int I_W       = 15,
  parameter int I_SHIFT   = 6,
  parameter int D_SAT_W   = 7,
  parameter int PID_W     = 14,
  parameter int OUT_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               moving,
  input  logic               err_vld,
  input  logic [ERR_W-1:0]   error,
  input  logic [FRWRD_W-1:0] frwrd,
  input  logic [4:0]         p_coeff,
  input  logic [5:0]         d_coeff,
  output logic [SPD_W-1:0]   lft_spd,
  output logic [SPD_W-1:0]   rght_spd,
  output logic               spd_vld,
  output logic               i_sat
);

  localparam int P_W   = SAT_W + 6;
  localparam int D_W   = D_SAT_W + 7;
  localparam int SUM_W = ((P_W > I_W) ? P_W : I_W) + 3;
  localparam int L_W   = SPD_W + 1;

  localparam logic signed [ERR_W-1:0] ERR_HI = ERR_W'((2**(SAT_W-1)) - 1);
  localparam logic signed [ERR_W-1:0] ERR_LO = ERR_W'(-(2**(SAT_W-1)));
  localparam logic signed [SAT_W:0]   DIF_HI = (SAT_W+1)'((2**(D_SAT_W-1)) - 1);
  localparam logic signed [SAT_W:0]   DIF_LO = (SAT_W+1)'(-(2**(D_SAT_W-1)));
  localparam logic signed [I_W:0]     ACC_HI = (I_W+1)'((2**(I_W-1)) - 1);
  localparam logic signed [I_W:0]     ACC_LO = (I_W+1)'(-(2**(I_W-1)));
  localparam logic signed [SUM_W-1:0] PID_HI = SUM_W'((2**(PID_W-1)) - 1);
  localparam logic signed [SUM_W-1:0] PID_LO = SUM_W'(-(2**(PID_W-1)));
  localparam logic signed [L_W-1:0]   SPD_HI = L_W'((2**(SPD_W-1)) - 1);
  localparam logic signed [L_W-1:0]   SPD_LO = L_W'(-(2**(SPD_W-1)));

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  state_t state, state_nxt;
  logic   d_en;

  logic signed [ERR_W-1:0]   err_s;
  logic signed [SAT_W-1:0]   err_sat, prev_err;
  logic signed [SAT_W:0]     diff;
  logic signed [D_SAT_W-1:0] diff_sat;
  logic signed [P_W-1:0]     p_prod, p_r;
  logic signed [D_W-1:0]     d_prod, d_r;
  logic signed [I_W:0]       acc_sum;
  logic signed [I_W-1:0]     acc, acc_nxt, i_term;
  logic                      sat_nxt;
  logic                      s1_vld;
  logic signed [SUM_W-1:0]   pid_sum;
  logic signed [PID_W-1:0]   pid_clip, adj;
  logic signed [L_W-1:0]     frwrd_e, adj_e, l_sum, r_sum;
  logic signed [SPD_W-1:0]   l_clip, r_clip;

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!moving) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = PRIME;
        PRIME:   if (err_vld) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    d_en = (state == RUN);
  end

  // Stage 1 arithmetic
  assign err_s = error;

  always_comb begin
    if (err_s > ERR_HI)      err_sat = SAT_W'(ERR_HI);
    else if (err_s < ERR_LO) err_sat = SAT_W'(ERR_LO);
    else                     err_sat = SAT_W'(err_s);
  end

  assign diff = (SAT_W+1)'(err_sat) - (SAT_W+1)'(prev_err);

  always_comb begin
    if (diff > DIF_HI)      diff_sat = D_SAT_W'(DIF_HI);
    else if (diff < DIF_LO) diff_sat = D_SAT_W'(DIF_LO);
    else                    diff_sat = D_SAT_W'(diff);
  end

  // Gains are zero-extended so the products stay signed.
  assign p_prod = P_W'(err_sat) * P_W'($signed({1'b0, p_coeff}));
  assign d_prod = D_W'(diff_sat) * D_W'($signed({1'b0, d_coeff}));

  assign acc_sum = (I_W+1)'(acc) + (I_W+1)'(err_sat);

  always_comb begin
    sat_nxt = 1'b0;
    acc_nxt = I_W'(acc_sum);
    if (acc_sum > ACC_HI) begin
      acc_nxt = I_W'(ACC_HI);
      sat_nxt = 1'b1;
    end else if (acc_sum < ACC_LO) begin
      acc_nxt = I_W'(ACC_LO);
      sat_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r      <= '0;
      d_r      <= '0;
      acc      <= '0;
      prev_err <= '0;
      i_sat    <= 1'b0;
      s1_vld   <= 1'b0;
    end else if (!moving) begin
      acc      <= '0;
      prev_err <= '0;
      i_sat    <= 1'b0;
      s1_vld   <= 1'b0;
    end else begin
      s1_vld <= err_vld;
      if (err_vld) begin
        p_r      <= p_prod;
        d_r      <= d_en ? d_prod : '0;
        acc      <= acc_nxt;
        i_sat    <= sat_nxt;
        prev_err <= err_sat;
      end
    end
  end

  // Stage 2 arithmetic; frwrd is taken live when the sample reaches this stage.
  assign i_term  = acc >>> I_SHIFT;
  assign pid_sum = SUM_W'(p_r) + SUM_W'(i_term) + SUM_W'(d_r);

  always_comb begin
    if (pid_sum > PID_HI)      pid_clip = PID_W'(PID_HI);
    else if (pid_sum < PID_LO) pid_clip = PID_W'(PID_LO);
    else                       pid_clip = PID_W'(pid_sum);
  end

  assign adj     = pid_clip >>> OUT_SHIFT;
  assign frwrd_e = L_W'({1'b0, frwrd});
  // After the shift adj fits in PID_W-OUT_SHIFT bits, so narrowing is lossless.
  assign adj_e   = L_W'(adj);
  assign l_sum   = frwrd_e + adj_e;
  assign r_sum   = frwrd_e - adj_e;

  always_comb begin
    if (l_sum > SPD_HI)      l_clip = SPD_W'(SPD_HI);
    else if (l_sum < SPD_LO) l_clip = SPD_W'(SPD_LO);
    else                     l_clip = SPD_W'(l_sum);
    if (r_sum > SPD_HI)      r_clip = SPD_W'(SPD_HI);
    else if (r_sum < SPD_LO) r_clip = SPD_W'(SPD_LO);
    else                     r_clip = SPD_W'(r_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_spd  <= '0;
      rght_spd <= '0;
      spd_vld  <= 1'b0;
    end else if (!moving) begin
      lft_spd  <= '0;
      rght_spd <= '0;
      spd_vld  <= 1'b0;
    end else begin
      spd_vld <= s1_vld;
      if (s1_vld) begin
        lft_spd  <= l_clip;
        rght_spd <= r_clip;
      end
    end
  end

endmodule

// File: tb/tb_pid_steer_ctrl.sv
module tb_pid_steer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        moving;
  logic        err_vld;
  logic [11:0] error;
  logic [9:0]  frwrd;
  logic [4:0]  p_coeff;
  logic [5:0]  d_coeff;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic        spd_vld;
  logic        i_sat;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {int l; int r; int cyc;} exp_t;
  exp_t sb_q[$];

  // reference model state
  int m_acc   = 0;
  int m_prev  = 0;
  int m_isat  = 0;
  int m_first = 1;

  pid_steer_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .moving   (moving),
    .err_vld  (err_vld),
    .error    (error),
    .frwrd    (frwrd),
    .p_coeff  (p_coeff),
    .d_coeff  (d_coeff),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .spd_vld  (spd_vld),
    .i_sat    (i_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clampi(int v, int w);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic chk(string tag, int obs, int exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    m_acc = 0; m_prev = 0; m_isat = 0; m_first = 1;
  endtask

  task automatic model_push(int e, int p, int d, int f, int out_cyc);
    int es, pt, dt, s, it, sum, adj;
    exp_t x;
    es = clampi(e, 10);
    pt = es * p;
    dt = m_first ? 0 : clampi(es - m_prev, 7) * d;
    s  = m_acc + es;
    if (s > 16383)       begin m_acc = 16383;  m_isat = 1; end
    else if (s < -16384) begin m_acc = -16384; m_isat = 1; end
    else                 begin m_acc = s;      m_isat = 0; end
    m_prev  = es;
    m_first = 0;
    it  = m_acc >>> 6;
    sum = clampi(pt + it + dt, 14);
    adj = sum >>> 3;
    x.l = clampi(f + adj, 11);
    x.r = clampi(f - adj, 11);
    x.cyc = out_cyc;
    sb_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(int e);
    err_vld = 1'b1;
    error   = 12'(e);
    model_push(e, int'(p_coeff), int'(d_coeff), int'(frwrd), cyc + 2);
    tick();
    err_vld = 1'b0;
  endtask

  // scoreboard consumer
  always @(negedge clk) begin
    if (rst_n === 1'b1 && spd_vld === 1'b1) begin
      tests++;
      assert (sb_q.size() > 0) else begin
        fails++;
        $error("FAIL spurious_spd_vld observed=1 expected=0 at cycle %0d", cyc);
      end
      if (sb_q.size() > 0) begin
        exp_t x;
        x = sb_q.pop_front();
        chk("lft_spd", int'($signed(lft_spd)), x.l);
        chk("rght_spd", int'($signed(rght_spd)), x.r);
        chk("latency_cycle", cyc, x.cyc);
      end
    end
  end

  initial begin
    rst_n = 1'b0; moving = 1'b0; err_vld = 1'b0; error = '0;
    frwrd = '0; p_coeff = '0; d_coeff = '0;
    repeat (3) tick();
    chk("rst_lft", int'($signed(lft_spd)), 0);
    chk("rst_rght", int'($signed(rght_spd)), 0);
    chk("rst_vld", int'(spd_vld), 0);
    chk("rst_isat", int'(i_sat), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outs", int'({lft_spd, rght_spd, spd_vld, i_sat}), 0);
    end

    // basic P + I
    frwrd = 10'd256; p_coeff = 5'd8; d_coeff = 6'd11; moving = 1'b1;
    tick();
    sample(64);
    repeat (3) tick();
    // D clamp with new forward command
    sample(0);
    repeat (3) tick();
    frwrd = 10'd512;
    sample(256);
    repeat (3) tick();
    // PID clamp and speed clamp; gain change applies to this sample
    p_coeff = 5'd31; frwrd = 10'd1023;
    sample(2047);
    repeat (3) tick();

    // integrator saturation with back-to-back samples
    moving = 1'b0;
    tick();
    model_clear();
    chk("drop_lft", int'($signed(lft_spd)), 0);
    chk("drop_isat", int'(i_sat), 0);
    moving = 1'b1; p_coeff = '0; d_coeff = '0; frwrd = 10'd300;
    tick();
    for (int i = 1; i <= 40; i++) begin
      sample(511);
      chk("i_sat_track", int'(i_sat), m_isat);
    end
    chk("i_sat_held", int'(i_sat), 1);
    repeat (3) tick();

    // moving drop with a sample in flight
    p_coeff = 5'd8; d_coeff = 6'd11;
    sample(100);
    moving = 1'b0;
    tick();
    sb_q.delete();
    model_clear();
    chk("flush_lft", int'($signed(lft_spd)), 0);
    chk("flush_rght", int'($signed(rght_spd)), 0);
    chk("flush_vld", int'(spd_vld), 0);
    chk("flush_isat", int'(i_sat), 0);
    repeat (3) tick();
    // sample with moving=0 is discarded
    err_vld = 1'b1; error = 12'd50;
    tick();
    err_vld = 1'b0;
    repeat (3) tick();
    chk("discard_lft", int'($signed(lft_spd)), 0);
    // restart: D=0 on first sample, acc from 0
    moving = 1'b1;
    tick();
    sample(100);
    sample(-30);
    repeat (3) tick();

    // async reset mid-pipeline
    sample(200);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    model_clear();
    chk("arst_lft", int'($signed(lft_spd)), 0);
    chk("arst_rght", int'($signed(rght_spd)), 0);
    chk("arst_vld", int'(spd_vld), 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    sample(40);
    repeat (4) tick();

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
